// File: rtl/tiny32_timer_ctrl.sv
// Tiny32 memory-mapped down-counting timer with prescaler, pending flag,
// interrupt request and WFI wake strobe behind a simple req/ready I/O bus.
module tiny32_timer_ctrl #(
   parameter int TIMER_BITS     = 32,
   parameter int PRESCALER_BITS = 4
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        io_req,
   input  logic        io_nwr,
   input  logic [1:0]  io_address,
   input  logic [31:0] io_data_in,
   output logic [31:0] io_data_out,
   output logic        io_ready,
   input  logic        wfi,
   input  logic        irq_ack,
   output logic        irq,
   output logic        wake
);

   localparam int PW = (PRESCALER_BITS > 0) ? PRESCALER_BITS : 1;
   localparam logic [TIMER_BITS-1:0] COUNT_ONE = TIMER_BITS'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      WAIT = 2'd2
   } bus_state_t;

   bus_state_t            state;
   bus_state_t            state_next;
   logic                  en;
   logic                  ie;
   logic                  auto_reload;
   logic [TIMER_BITS-1:0] reload;
   logic [TIMER_BITS-1:0] count;
   logic                  pend;
   logic [PW-1:0]         presc;
   logic [31:0]           read_data;
   logic                  commit;
   logic                  wr_ctrl;
   logic                  wr_reload;
   logic                  wr_count;
   logic                  wr_status;
   logic                  tick;
   logic                  expire;

   // The access takes effect only on the IDLE->ACK edge, so a held request cannot repeat it.
   assign commit    = (state == IDLE) && io_req;
   assign wr_ctrl   = commit && !io_nwr && (io_address == 2'd0);
   assign wr_reload = commit && !io_nwr && (io_address == 2'd1);
   assign wr_count  = commit && !io_nwr && (io_address == 2'd2);
   assign wr_status = commit && !io_nwr && (io_address == 2'd3);

   generate
      if (PRESCALER_BITS == 0) begin : g_no_presc
         assign tick = en;
      end else begin : g_presc
         assign tick = en && (presc == {PW{1'b1}});
      end
   endgenerate

   // A direct COUNT write pre-empts both the decrement and the expiry check.
   assign expire = tick && (count == '0) && !wr_count;
   assign wake   = pend & wfi;

   // Bus state register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Bus next-state decode
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (io_req) begin
               state_next = ACK;
            end else begin
               state_next = IDLE;
            end
         end
         ACK: state_next = WAIT;
         WAIT: begin
            if (!io_req) begin
               state_next = IDLE;
            end else begin
               state_next = WAIT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Register read multiplexer
   always_comb begin
      read_data = 32'd0;
      case (io_address)
         2'd0:    read_data = {29'd0, auto_reload, ie, en};
         2'd1:    read_data = 32'(reload);
         2'd2:    read_data = 32'(count);
         2'd3:    read_data = {31'd0, pend};
         default: read_data = 32'd0;
      endcase
   end

   // Bus acknowledge and read-data capture
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         io_ready    <= 1'b0;
         io_data_out <= 32'd0;
      end else begin
         io_ready    <= commit;
         io_data_out <= (commit && io_nwr) ? read_data : 32'd0;
      end
   end

   // Control and reload registers; one-shot expiry drops EN unless CTRL is written
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         en          <= 1'b0;
         ie          <= 1'b0;
         auto_reload <= 1'b0;
         reload      <= '0;
      end else begin
         if (wr_ctrl) begin
            en          <= io_data_in[0];
            ie          <= io_data_in[1];
            auto_reload <= io_data_in[2];
         end else if (expire && !auto_reload) begin
            en <= 1'b0;
         end else begin
            en <= en;
         end
         if (wr_reload) begin
            reload <= io_data_in[TIMER_BITS-1:0];
         end else begin
            reload <= reload;
         end
      end
   end

   // Prescaler
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         presc <= '0;
      end else if (wr_ctrl) begin
         presc <= '0;
      end else if (en) begin
         presc <= presc + PW'(1);
      end else begin
         presc <= presc;
      end
   end

   // Down counter
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         count <= '0;
      end else if (wr_count) begin
         count <= io_data_in[TIMER_BITS-1:0];
      end else if (tick && (count != '0)) begin
         count <= count - COUNT_ONE;
      end else if (expire && auto_reload) begin
         count <= reload;
      end else begin
         count <= count;
      end
   end

   // Pending flag and registered interrupt; a new expiry beats any clear
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pend <= 1'b0;
         irq  <= 1'b0;
      end else begin
         if (expire) begin
            pend <= 1'b1;
         end else if (irq_ack || (wr_status && io_data_in[0])) begin
            pend <= 1'b0;
         end else begin
            pend <= pend;
         end
         irq <= pend & ie;
      end
   end

endmodule

// File: tb/tb_tiny32_timer_ctrl.sv
// Self-checking bench for tiny32_timer_ctrl: directed tables and sequences plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_tiny32_timer_ctrl;

   localparam int PB   = 2;
   localparam int PMOD = 1 << PB;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        io_req = 1'b0;
   logic        io_nwr = 1'b1;
   logic [1:0]  io_address = 2'd0;
   logic [31:0] io_data_in = 32'd0;
   logic [31:0] io_data_out;
   logic        io_ready;
   logic        wfi = 1'b0;
   logic        irq_ack = 1'b0;
   logic        irq;
   logic        wake;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int irq_rises[$];
   int wake_rises[$];
   logic last_irq = 1'b0;
   logic last_wake = 1'b0;

   // behavioural model state
   logic        m_en, m_ie, m_auto, m_pend, m_busy, m_ready, m_irq;
   logic [31:0] m_reload, m_count, m_dout;
   int          m_pre;

   tiny32_timer_ctrl #(.TIMER_BITS(32), .PRESCALER_BITS(PB)) dut (
      .clk(clk), .nreset(nreset), .io_req(io_req), .io_nwr(io_nwr),
      .io_address(io_address), .io_data_in(io_data_in), .io_data_out(io_data_out),
      .io_ready(io_ready), .wfi(wfi), .irq_ack(irq_ack), .irq(irq), .wake(wake)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 1'b0; m_ie = 1'b0; m_auto = 1'b0; m_pend = 1'b0;
      m_busy = 1'b0; m_ready = 1'b0; m_irq = 1'b0;
      m_reload = 32'd0; m_count = 32'd0; m_dout = 32'd0; m_pre = 0;
   endtask

   // one rising edge of the timer as described by its register-level rules
   task automatic model_step();
      logic        acc, wr, rd, tick, expire, wr_cnt, clr;
      logic [31:0] rv;
      acc    = !m_busy && io_req;
      wr     = acc && !io_nwr;
      rd     = acc && io_nwr;
      case (io_address)
         2'd0:    rv = {29'd0, m_auto, m_ie, m_en};
         2'd1:    rv = m_reload;
         2'd2:    rv = m_count;
         default: rv = {31'd0, m_pend};
      endcase
      wr_cnt = wr && (io_address == 2'd2);
      tick   = m_en && (m_pre == PMOD - 1);
      expire = tick && (m_count == 32'd0) && !wr_cnt;
      clr    = irq_ack || (wr && (io_address == 2'd3) && io_data_in[0]);

      m_irq  = m_pend & m_ie;
      m_busy = acc || (m_busy && (m_ready || io_req));
      m_ready = acc;
      m_dout = rd ? rv : 32'd0;

      if (wr && io_address == 2'd0) m_pre = 0;
      else if (m_en) m_pre = (m_pre + 1) % PMOD;

      if (expire) m_pend = 1'b1;
      else if (clr) m_pend = 1'b0;

      if (wr_cnt) m_count = io_data_in;
      else if (tick && m_count != 32'd0) m_count = m_count - 32'd1;
      else if (expire && m_auto) m_count = m_reload;

      if (wr && io_address == 2'd0) begin
         m_en = io_data_in[0]; m_ie = io_data_in[1]; m_auto = io_data_in[2];
      end else if (expire && !m_auto) begin
         m_en = 1'b0;
      end
      if (wr && io_address == 2'd1) m_reload = io_data_in;
   endtask

   task automatic cycle();
      if (nreset) model_step();
      @(posedge clk);
      #1;
      cyc++;
      chk("io_ready", 32'(io_ready), 32'(m_ready));
      chk("io_data_out", io_data_out, m_dout);
      chk("irq", 32'(irq), 32'(m_irq));
      chk("wake", 32'(wake), 32'(m_pend & wfi));
      if (irq && !last_irq) irq_rises.push_back(cyc);
      if (wake && !last_wake) wake_rises.push_back(cyc);
      last_irq = irq;
      last_wake = wake;
   endtask

   task automatic bus_op(input bit wr, input logic [1:0] a, input logic [31:0] d,
                         input int hold, output logic [31:0] rd);
      int readies = 0;
      int first = -1;
      rd = 32'd0;
      io_req = 1'b1; io_nwr = !wr; io_address = a; io_data_in = d;
      for (int i = 0; i < 8 && first < 0; i++) begin
         cycle();
         if (io_ready) begin
            first = i; readies++; rd = io_data_out;
         end
      end
      chk("bus_latency", 32'(first), 32'd0);
      for (int i = 0; i < hold + 1; i++) begin
         cycle();
         if (io_ready) readies++;
      end
      io_req = 1'b0;
      cycle();
      if (io_ready) readies++;
      chk("bus_single_ready", 32'(readies), 32'd1);
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      bus_op(1'b1, a, d, 0, dummy);
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
      logic [31:0] v;
      bus_op(1'b0, a, 32'd0, 0, v);
      chk(name, v, exp);
   endtask

   typedef struct {
      bit          wr;
      logic [1:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int start, r, lim, handled;
      logic [31:0] rd;
      logic [1:0]  a;
      logic [31:0] d;

      vecs[0] = '{1'b1, 2'd1, 32'h1234_5678, 32'd0};
      vecs[1] = '{1'b0, 2'd0, 32'd0, 32'd0};
      vecs[2] = '{1'b0, 2'd1, 32'd0, 32'h1234_5678};
      vecs[3] = '{1'b0, 2'd2, 32'd0, 32'd0};
      vecs[4] = '{1'b0, 2'd3, 32'd0, 32'd0};
      vecs[5] = '{1'b1, 2'd0, 32'hFFFF_FFF8, 32'd0};
      vecs[6] = '{1'b0, 2'd0, 32'd0, 32'd0};
      vecs[7] = '{1'b1, 2'd2, 32'hDEAD_BEEF, 32'd0};
      vecs[8] = '{1'b0, 2'd2, 32'd0, 32'hDEAD_BEEF};
      vecs[9] = '{1'b1, 2'd3, 32'h0000_0000, 32'd0};

      model_reset();
      for (int i = 0; i < 3; i++) cycle();
      nreset = 1'b1;
      cycle();

      // register readback table
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].data);
         else rd_chk(vecs[i].addr, vecs[i].exp, $sformatf("table_read_%0d", i));
      end

      // held request: one acknowledge, one write
      bus_op(1'b1, 2'd2, 32'h55, 3, rd);
      rd_chk(2'd2, 32'h55, "held_write_count");

      // periodic expiry with auto reload
      wr_reg(2'd3, 32'd1);
      wr_reg(2'd1, 32'd3);
      wr_reg(2'd2, 32'd3);
      wfi = 1'b1;
      irq_rises.delete();
      wake_rises.delete();
      wr_reg(2'd0, 32'd7);
      handled = 0;
      lim = cyc + 200;
      while (irq_rises.size() < 4 && cyc < lim) begin
         cycle();
         if (irq_rises.size() > handled) begin
            handled++;
            irq_ack = 1'b1;
            cycle();
            irq_ack = 1'b0;
            rd_chk(2'd2, 32'd3, "periodic_reload");
         end
      end
      chk("periodic_expiries", 32'(irq_rises.size()), 32'd4);
      if (irq_rises.size() == 4 && wake_rises.size() >= 4) begin
         for (int i = 1; i < 4; i++)
            chk("periodic_interval", 32'(irq_rises[i] - irq_rises[i-1]), 32'd16);
         for (int i = 0; i < 4; i++)
            chk("irq_after_pend", 32'(irq_rises[i] - wake_rises[i]), 32'd1);

         // acknowledge in the expiry cycle, then one cycle later
         r = irq_rises[3];
         while (cyc < r + 14) cycle();
         irq_ack = 1'b1;
         cycle();
         irq_ack = 1'b0;
         chk("race_same_cycle_pend", 32'(wake), 32'd1);
         irq_ack = 1'b1;
         cycle();
         irq_ack = 1'b0;
         chk("race_late_pend", 32'(wake), 32'd0);
         cycle();
         chk("race_late_irq", 32'(irq), 32'd0);
      end
      wfi = 1'b0;

      // one-shot
      wr_reg(2'd0, 32'd0);
      wr_reg(2'd3, 32'd1);
      wr_reg(2'd2, 32'd2);
      wr_reg(2'd0, 32'd3);
      start = cyc;
      lim = cyc + 40;
      while (!irq && cyc < lim) cycle();
      chk("oneshot_delay", 32'(cyc - start), 32'd11);
      rd_chk(2'd0, 32'd2, "oneshot_ctrl");
      rd_chk(2'd2, 32'd0, "oneshot_count");
      wr_reg(2'd3, 32'd1);
      irq_rises.delete();
      for (int i = 0; i < 40; i++) cycle();
      chk("oneshot_no_reexpiry", 32'(irq_rises.size()), 32'd0);
      rd_chk(2'd3, 32'd0, "oneshot_status");

      // wake with interrupts disabled
      wr_reg(2'd2, 32'd1);
      wr_reg(2'd0, 32'd1);
      wfi = 1'b1;
      lim = cyc + 30;
      while (!wake && cyc < lim) cycle();
      chk("wfi_wake", 32'(wake), 32'd1);
      cycle();
      chk("wfi_irq_quiet", 32'(irq), 32'd0);
      wr_reg(2'd3, 32'd0);
      chk("status_write0_keeps", 32'(wake), 32'd1);
      wr_reg(2'd3, 32'd1);
      chk("status_clear_wake", 32'(wake), 32'd0);
      wfi = 1'b0;

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         a = 2'($urandom_range(0, 3));
         if (r < 4) begin
            d = $urandom;
            if ((a == 2'd1 || a == 2'd2) && $urandom_range(0, 7) != 0) d = 32'($urandom_range(0, 12));
            bus_op(1'b1, a, d, $urandom_range(0, 2), rd);
         end else if (r < 6) begin
            bus_op(1'b0, a, 32'd0, $urandom_range(0, 2), rd);
         end else begin
            irq_ack = ($urandom_range(0, 3) == 0);
            wfi = 1'($urandom_range(0, 1));
            cycle();
            irq_ack = 1'b0;
         end
      end
      wfi = 1'b1;

      // reset in the middle of an access
      wr_reg(2'd1, 32'd2);
      wr_reg(2'd2, 32'd2);
      wr_reg(2'd0, 32'd7);
      lim = cyc + 40;
      while (!irq && cyc < lim) cycle();
      chk("pre_reset_irq", 32'(irq), 32'd1);
      io_req = 1'b1; io_nwr = 1'b0; io_address = 2'd1; io_data_in = 32'hA5A5_A5A5;
      cycle();
      chk("pre_reset_ack", 32'(io_ready), 32'd1);
      #2;
      nreset = 1'b0;
      #1;
      model_reset();
      chk("reset_ready_async", 32'(io_ready), 32'd0);
      chk("reset_dout_async", io_data_out, 32'd0);
      chk("reset_irq_async", 32'(irq), 32'd0);
      chk("reset_wake_async", 32'(wake), 32'd0);
      cycle();
      cycle();
      io_req = 1'b0;
      nreset = 1'b1;
      rd_chk(2'd0, 32'd0, "reset_ctrl");
      rd_chk(2'd1, 32'd0, "reset_reload");
      rd_chk(2'd2, 32'd0, "reset_count");
      rd_chk(2'd3, 32'd0, "reset_status");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tiny32_timer_ctrl.md
# tiny32_timer_ctrl

Memory-mapped timer and interrupt controller for the Tiny32 SoC. It counts down a programmable period, raises an interrupt request to the CPU core, and produces a wake strobe that releases the core from WFI. It sits on the core's I/O bus beside the LED and GPIO peripherals, and it replaces the free-running blink divider used in the test SoC.

## Interface
- TIMER_BITS, 32: width of the count and reload registers (1..32).
- PRESCALER_BITS, 4: the timer ticks once every 2^PRESCALER_BITS enabled clocks (0 means tick every clock).
- clk  in  1  system clock; all state changes on the rising edge.
- nreset  in  1  reset, asynchronous and active-low; asserting it clears all state immediately.
- io_req  in  1  bus request, held high by the master until io_ready is seen.
- io_nwr  in  1  0 = write, 1 = read; stable while io_req is high.
- io_address  in  2  register select.
- io_data_in  in  32  write data.
- io_data_out  out  32  read data, valid while io_ready is high, 0 otherwise.
- io_ready  out  1  bus acknowledge.
- wfi  in  1  core is in wait-for-interrupt.
- irq_ack  in  1  one-cycle interrupt acknowledge from the core.
- irq  out  1  interrupt request.
- wake  out  1  wake request to the core.

## Operation
- Register map:
  - 0 CTRL: bit0 EN, bit1 IE, bit2 AUTO. All other bits read 0.
  - 1 RELOAD: reload value.
  - 2 COUNT: current count. A write loads the count directly.
  - 3 STATUS: bit0 PEND. Writing 1 to bit0 clears PEND. Writing 0 has no effect.
- Width rules:
  - Reads of RELOAD and COUNT are zero-extended to 32 bits.
  - Writes are truncated to TIMER_BITS.
- Prescaler:
  - PRESCALER_BITS-wide counter. It increments while EN=1.
  - A tick is produced in the cycle the prescaler equals all ones.
  - Any CTRL write clears the prescaler.
- Counter, on each tick:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0 (expiry): PEND is set. If AUTO=1, COUNT is loaded from RELOAD. If AUTO=0, COUNT stays 0 and EN clears.
- Outputs:
  - irq = PEND & IE, registered from PEND/IE state (no combinational path from the bus).
  - wake = PEND & wfi, combinational from the PEND register. wake ignores IE, so polling software can still sleep.
- PEND clears on either irq_ack=1 or a STATUS write-1.
- Priority when events coincide:
  - Expiry in the same cycle as an irq_ack or a STATUS clear: PEND stays 1. The new event wins.
  - Bus write to COUNT in the same cycle as a tick: the write wins, with no decrement that cycle. Expiry is evaluated on the pre-write count only if no write is present.
  - Bus write to CTRL setting EN=0 in the same cycle as an expiry: EN=0 wins, and PEND is still set.
- Bus state machine:
  - IDLE: io_req=1 → ACK. The write is committed on this transition edge. Read data is captured into io_data_out.
  - ACK: io_ready=1 for exactly one cycle → WAIT.
  - WAIT: remain until io_req=0 → IDLE. This prevents a duplicate access from a held request.
  - io_address and io_nwr are sampled only at IDLE→ACK.
- Reset mid-transaction: the state machine returns to IDLE, io_ready and io_data_out drop to 0 asynchronously, and the write is lost if it has not yet committed.

## Timing
- Reset values: CTRL=0, RELOAD=0, COUNT=0, PEND=0, prescaler=0, state=IDLE, io_ready=0, io_data_out=0, irq=0. wake=0 because PEND=0.
- Bus latency: io_ready rises 1 cycle after io_req is first sampled high. The minimum transaction is 3 cycles including the release.
- A register written at edge N is visible to the counter logic from edge N+1.
- Period with AUTO=1: (RELOAD+1)·2^PRESCALER_BITS cycles between expiries.
- Expiry sets PEND at the tick edge. irq rises 1 cycle later. wake rises in the same cycle PEND is 1 and wfi=1.
- irq_ack sampled at edge N: PEND=0 after N, irq=0 after N+1.

## Test plan
- Reset and readback:
  - Deassert nreset, write RELOAD=0x12345678, then read each register.
  - Required: RELOAD reads 0x12345678. CTRL, COUNT and STATUS read 0. io_ready is high for exactly one cycle per access.
- Periodic expiry:
  - PRESCALER_BITS=2, RELOAD=3, COUNT=3, CTRL=0b111.
  - Required: PEND sets every 16 cycles. irq follows PEND 1 cycle later. COUNT reloads to 3.
- One-shot:
  - CTRL=0b011 with AUTO=0, COUNT=2.
  - Required: a single expiry after 3 ticks. EN reads 0 and COUNT stays 0 afterwards, with no further PEND.
- Acknowledge races:
  - Pulse irq_ack in the exact expiry cycle. Required: PEND remains 1.
  - Pulse irq_ack one cycle later. Required: PEND=0 and irq=0 on the next edge.
- WFI wake with interrupts disabled:
  - IE=0, wfi=1, expiry occurs.
  - Required: wake=1 while irq stays 0. Clearing STATUS via a write of 1 drops wake.
- Held request and reset mid-access:
  - Hold io_req high for 5 cycles on a write to COUNT. Required: exactly one io_ready and one write.
  - Assert nreset during ACK. Required: io_ready=0 immediately and every register at its reset value.
